// File: rtl/lc3_console_tx.sv
// LC-3 display output port: DDR stores are queued in a FIFO and drained by a
// UART serializer. DSR[15] reads "FIFO not full" so OUT/PUTS polling only stalls when full.
module lc3_console_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Ddr_Wr,
    input  logic [15:0]                   i_Ddr_Data,
    input  logic                          i_Ovf_Clr,
    output logic [15:0]                   o_Dsr,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Tx_Serial
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int STOP_LEN = CLKS_PER_BIT * STOP_BITS;
    localparam int CW       = $clog2(STOP_LEN);
    localparam int IW       = $clog2(DATA_BITS);

    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  STOP_LAST = CW'(STOP_LEN - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  serial_q, serial_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;

    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]  head;
    logic                  full, pop, push, load;

    // Only the low DATA_BITS of the bus word are transmitted.
    logic unused_ddr_hi;
    assign unused_ddr_hi = ^i_Ddr_Data[15:DATA_BITS];

    assign head = mem[rd_ptr_q];
    assign full = (count_q == DEPTH_C);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = serial_q;
        load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                load     = (count_q != '0);
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    // Back-to-back frames: a waiting byte starts with no idle gap.
                    load = (count_q != '0);
                    if (count_q == '0) begin
                        state_d  = S_IDLE;
                        serial_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
            end
        endcase

        pop = load;
        if (load) begin
            shift_d  = head;
            par_d    = (^head) ^ PAR_ODD;
            state_d  = S_START;
            cnt_d    = '0;
            serial_d = 1'b0;
        end

        // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
        push     = i_Ddr_Wr && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (i_Ddr_Wr && full && !pop) ovf_d = 1'b1;
        else if (i_Ovf_Clr)           ovf_d = 1'b0;
        else                          ovf_d = ovf_q;

        done_d = (state_d == S_STOP) && (cnt_d == STOP_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count decides which entries are valid.
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr_q] <= i_Ddr_Data[DATA_BITS-1:0];
    end

    assign o_Dsr        = {~full, 15'b0};
    assign o_Fifo_Count = count_q;
    assign o_Overflow   = ovf_q;
    assign o_Tx_Active  = (state_q != S_IDLE);
    assign o_Tx_Done    = done_q;
    assign o_Tx_Serial  = serial_q;

endmodule

// File: tb/tb_lc3_console_tx.sv
// Bench for lc3_console_tx: an 8N1 instance checked through a frame-decoding scoreboard,
// plus 8E1 and 8O2 instances checked cycle by cycle for parity and stop length.
module tb_lc3_console_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = CPB * 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, ovf_clr = 1'b0;
    logic [15:0] data = '0;
    logic [15:0] dsr;
    logic [2:0]  cnt;
    logic        ovf, act, done, tx;

    logic        wr_e = 1'b0, wr_o = 1'b0;
    logic [15:0] pdata = '0;
    logic [15:0] dsr_e, dsr_o;
    logic [2:0]  cnt_e, cnt_o;
    logic        ovf_e, ovf_o, act_e, act_o, done_e, done_o, tx_e, tx_o;

    lc3_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_Ddr_Wr(wr), .i_Ddr_Data(data), .i_Ovf_Clr(ovf_clr),
        .o_Dsr(dsr), .o_Fifo_Count(cnt), .o_Overflow(ovf), .o_Tx_Active(act),
        .o_Tx_Done(done), .o_Tx_Serial(tx));

    lc3_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
        .i_Clk(clk), .i_Rst(rst), .i_Ddr_Wr(wr_e), .i_Ddr_Data(pdata), .i_Ovf_Clr(1'b0),
        .o_Dsr(dsr_e), .o_Fifo_Count(cnt_e), .o_Overflow(ovf_e), .o_Tx_Active(act_e),
        .o_Tx_Done(done_e), .o_Tx_Serial(tx_e));

    lc3_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_odd (
        .i_Clk(clk), .i_Rst(rst), .i_Ddr_Wr(wr_o), .i_Ddr_Data(pdata), .i_Ovf_Clr(1'b0),
        .o_Dsr(dsr_o), .o_Fifo_Count(cnt_o), .o_Overflow(ovf_o), .o_Tx_Active(act_o),
        .o_Tx_Done(done_o), .o_Tx_Serial(tx_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] sb_q[$];
    int         starts[$];
    int         done_cnt = 0;

    bit         mon_busy = 1'b0;
    bit         mon_ok;
    int         mon_c, mon_b;
    logic [7:0] mon_bits, mon_exp;

    // Frame decoder for the 8N1 line: samples mid-bit and pops the scoreboard at frame end.
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (mon_busy) begin
                mon_c++;
            end else if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_c    = 0;
                mon_ok   = 1'b1;
                mon_bits = '0;
                starts.push_back(cyc);
            end
            if (mon_busy) begin
                if (act !== 1'b1) mon_ok = 1'b0;
                if (done !== (mon_c == FL - 1)) mon_ok = 1'b0;
                if (mon_c % CPB == CPB / 2) begin
                    mon_b = mon_c / CPB;
                    if (mon_b == 0) begin
                        if (tx !== 1'b0) mon_ok = 1'b0;
                    end else if (mon_b <= 8) begin
                        mon_bits[mon_b-1] = tx;
                    end else if (tx !== 1'b1) begin
                        mon_ok = 1'b0;
                    end
                end
                if (mon_c == FL - 1) begin
                    n_total++;
                    if (!mon_ok) $display("FAIL frame_format: data %h framing/done/active wrong, required clean 8N1 frame", mon_bits);
                    else n_pass++;
                    n_total++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL sb_data: got frame %h, required no frame", mon_bits);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        if (mon_bits !== mon_exp) $display("FAIL sb_data: got %h, required %h", mon_bits, mon_exp);
                        else n_pass++;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic ddr_write(input logic [15:0] d, input bit accepted);
        data = d;
        wr   = 1'b1;
        if (accepted) sb_q.push_back(d[7:0]);
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || mon_busy || act) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        n_total++;
        if (k >= 2000) $display("FAIL %s_drain: %0d frames outstanding, required 0", name, sb_q.size());
        else n_pass++;
    endtask

    function automatic logic exp_line(input int c, input logic [7:0] d, input int par, input int fl);
        int b;
        if (c < 0 || c >= fl) return 1'b1;
        b = c / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par != 0 && b == 9) return (^d) ^ (par == 2);
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_total++; if (tx !== 1'b1)       $display("FAIL reset_tx: got %b, required 1", tx);          else n_pass++;
        n_total++; if (dsr !== 16'h8000)  $display("FAIL reset_dsr: got %h, required 8000", dsr);     else n_pass++;
        n_total++; if (cnt !== 3'd0)      $display("FAIL reset_count: got %0d, required 0", cnt);     else n_pass++;
        n_total++; if (act !== 1'b0)      $display("FAIL reset_active: got %b, required 0", act);     else n_pass++;
        n_total++; if (ovf !== 1'b0)      $display("FAIL reset_ovf: got %b, required 0", ovf);        else n_pass++;
        n_total++; if (done !== 1'b0)     $display("FAIL reset_done: got %b, required 0", done);      else n_pass++;
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        ddr_write(16'h0041, 1'b1);
        n_total++; if (cnt !== 3'd1) $display("FAIL single_count_e: got %0d, required 1", cnt); else n_pass++;
        n_total++; if (tx !== 1'b1)  $display("FAIL single_tx_e: got %b, required 1", tx);      else n_pass++;
        @(posedge clk); #1;
        n_total++; if (tx !== 1'b0)  $display("FAIL single_tx_e1: got %b, required 0", tx);     else n_pass++;
        n_total++; if (act !== 1'b1) $display("FAIL single_active: got %b, required 1", act);   else n_pass++;
        n_total++; if (cnt !== 3'd0) $display("FAIL single_count_e1: got %0d, required 0", cnt); else n_pass++;
        wait_drain("single");
        n_total++;
        if (done_cnt - d0 != 1) $display("FAIL single_done_pulses: got %0d, required 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s0 = starts.size();
        for (int i = 0; i < 5; i++) ddr_write(16'(16'h0061 + i), 1'b1);
        n_total++; if (cnt !== 3'd4)     $display("FAIL b2b_count: got %0d, required 4", cnt);  else n_pass++;
        n_total++; if (dsr !== 16'h0000) $display("FAIL b2b_dsr_full: got %h, required 0000", dsr); else n_pass++;
        wait_drain("b2b");
        n_total++; if (ovf !== 1'b0) $display("FAIL b2b_ovf: got %b, required 0", ovf); else n_pass++;
        n_total++;
        if (starts.size() - s0 != 5) begin
            $display("FAIL b2b_frames: got %0d, required 5", starts.size() - s0);
        end else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if (starts[s0+i+1] - starts[s0+i] != FL)
                    $display("FAIL b2b_gap%0d: got %0d cycles, required %0d", i, starts[s0+i+1] - starts[s0+i], FL);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        int e0;
        int s0 = starts.size();
        ddr_write(16'h0030, 1'b1);
        e0 = cyc;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 5; i++) ddr_write(16'(16'h0030 + i), 1'b1);
        ddr_write(16'h0035, 1'b0);
        n_total++; if (ovf !== 1'b1)     $display("FAIL ovf_set: got %b, required 1", ovf);        else n_pass++;
        n_total++; if (dsr !== 16'h0000) $display("FAIL ovf_dsr: got %h, required 0000", dsr);     else n_pass++;
        n_total++; if (cnt !== 3'd4)     $display("FAIL ovf_count: got %0d, required 4", cnt);     else n_pass++;
        ovf_clr = 1'b1;
        ddr_write(16'h0036, 1'b0);
        ovf_clr = 1'b0;
        n_total++; if (ovf !== 1'b1)     $display("FAIL ovf_set_wins: got %b, required 1", ovf);   else n_pass++;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        n_total++; if (ovf !== 1'b0)     $display("FAIL ovf_clear: got %b, required 0", ovf);      else n_pass++;
        // Land a write on the edge where the first frame ends and pops the next byte.
        while (cyc < e0 + FL) begin
            @(posedge clk); #1;
        end
        ddr_write(16'h0037, 1'b1);
        n_total++; if (cnt !== 3'd4)     $display("FAIL full_pop_count: got %0d, required 4", cnt); else n_pass++;
        n_total++; if (ovf !== 1'b0)     $display("FAIL full_pop_ovf: got %b, required 0", ovf);    else n_pass++;
        wait_drain("ovf");
        n_total++;
        if (starts.size() - s0 != 6) $display("FAIL ovf_frames: got %0d, required 6", starts.size() - s0);
        else n_pass++;
    endtask

    task automatic test_parity(input bit odd);
        int         par = odd ? 2 : 1;
        int         stop = odd ? 2 : 1;
        int         fl = CPB * (1 + 8 + 1 + stop);
        logic [7:0] d = 8'h07;
        logic       req_par = odd ? 1'b0 : 1'b1;
        logic       got, dn, par_seen, expv;
        int         bad_at = -1;
        logic       bad_got = 1'b0, bad_exp = 1'b0;
        bit         done_ok = 1'b1;
        pdata = 16'h0007;
        if (odd) wr_o = 1'b1; else wr_e = 1'b1;
        @(posedge clk); #1;
        wr_o = 1'b0;
        wr_e = 1'b0;
        par_seen = 1'bx;
        for (int c = -1; c < fl + 2; c++) begin
            @(negedge clk);
            got  = odd ? tx_o : tx_e;
            dn   = odd ? done_o : done_e;
            expv = exp_line(c, d, par, fl);
            if (got !== expv && bad_at < 0) begin
                bad_at  = c;
                bad_got = got;
                bad_exp = expv;
            end
            if (dn !== (c == fl - 1)) done_ok = 1'b0;
            if (c == 9 * CPB + CPB / 2) par_seen = got;
        end
        n_total++;
        if (par_seen !== req_par) $display("FAIL parity_bit_p%0d: got %b, required %b", par, par_seen, req_par);
        else n_pass++;
        n_total++;
        if (bad_at >= 0) $display("FAIL parity_line_p%0d: cycle %0d got %b, required %b", par, bad_at, bad_got, bad_exp);
        else n_pass++;
        n_total++;
        if (!done_ok) $display("FAIL parity_done_p%0d: pulse not confined to cycle %0d, required exactly there", par, fl - 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        ddr_write(16'h0055, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (act !== 1'b1) $display("FAIL mid_active: got %b, required 1", act); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (tx !== 1'b1)      $display("FAIL mid_rst_tx: got %b, required 1", tx);        else n_pass++;
        n_total++; if (cnt !== 3'd0)     $display("FAIL mid_rst_count: got %0d, required 0", cnt);   else n_pass++;
        n_total++; if (act !== 1'b0)     $display("FAIL mid_rst_active: got %b, required 0", act);   else n_pass++;
        n_total++; if (dsr !== 16'h8000) $display("FAIL mid_rst_dsr: got %h, required 8000", dsr);   else n_pass++;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        ddr_write(16'h005A, 1'b1);
        wait_drain("reset_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_parity(1'b0);
        test_parity(1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
